pc_sequencer: RTL

//  Owns the 16-bit program counter and sequences instruction fetch.

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_next_calc.sv | 28 ++
 rtl/pc_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared definitions for the program-counter sequencer:
//   - state_t              : sequencer FSM encoding (IDLE/FETCH/DECODE/HALT)
//   - PC_INC               : sequential PC step in bytes (one 16-bit word)
//   - DEFAULT_RESET_VECTOR : PC value loaded on reset unless overridden
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   localparam int          PC_INC               = 2;
   localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc
//   Combinational next-PC arithmetic shared by the sequencer.
//   Ports:
//     pc            in   ADDR_W    current program counter
//     offset        in   OFFSET_W  signed branch offset, in 16-bit words
//     pc_plus2      out  ADDR_W    pc + 2, modulo 2^ADDR_W
//     branch_target out  ADDR_W    pc + 2 + (sext(offset) << 1), modulo 2^ADDR_W
module pc_next_calc
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int OFFSET_W = 8
) (
   input  logic [ADDR_W-1:0]   pc,
   input  logic [OFFSET_W-1:0] offset,
   output logic [ADDR_W-1:0]   pc_plus2,
   output logic [ADDR_W-1:0]   branch_target
);

   // Sign-extend and convert words to bytes in one concatenation; the
   // discarded top sign bit is never materialised.
   logic [ADDR_W-1:0] byte_offset;

   assign byte_offset   = {{(ADDR_W-OFFSET_W-1){offset[OFFSET_W-1]}}, offset, 1'b0};
   assign pc_plus2      = pc + ADDR_W'(PC_INC);
   assign branch_target = pc_plus2 + byte_offset;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter and sequences instruction fetch:
//   IDLE -> FETCH -> DECODE -> (FETCH | HALT), HALT -> FETCH on Resume.
//   Ports:
//     clk, rst_n    clock (rising edge), asynchronous active-low reset
//     Stall         in   blocks a new fetch request from starting
//     FetchReq      out  fetch request to instruction memory
//     FetchAddr     out  fetch address (always equals PC)
//     FetchAck      in   memory accepted/returned the request
//     InstrValid    out  registered one-cycle pulse, instruction captured
//     DecValid      in   decoder next-PC decision valid (DECODE only)
//     Halt/Jump/BranchTaken, JumpTarget, BranchOffset   decision inputs
//     Resume        in   leave HALT
//     PC, PCPlus2   out  current PC and PC+2
//     AlignErr      out  sticky flag, an odd jump target was seen
//     State         out  current FSM state (debug)
//
//   Handshake: a fetch transfers on a cycle where FetchReq && FetchAck.
//   Once FetchReq is raised it stays high with FetchAddr stable until that
//   transfer; Stall only gates the start of a request. FetchAck is ignored
//   while FetchReq is low.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W       = 16,
   parameter int                OFFSET_W     = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                Stall,
   output logic                FetchReq,
   output logic [ADDR_W-1:0]   FetchAddr,
   input  logic                FetchAck,
   output logic                InstrValid,
   input  logic                DecValid,
   input  logic                Halt,
   input  logic                Jump,
   input  logic [ADDR_W-1:0]   JumpTarget,
   input  logic                BranchTaken,
   input  logic [OFFSET_W-1:0] BranchOffset,
   input  logic                Resume,
   output logic [ADDR_W-1:0]   PC,
   output logic [ADDR_W-1:0]   PCPlus2,
   output logic                AlignErr,
   output logic [1:0]          State
);

   state_t            state, next_state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus2;
   logic [ADDR_W-1:0] branch_target;
   logic              req_held;
   logic              instr_valid;
   logic              align_err;
   logic              fetch_req;

   pc_next_calc #(
      .ADDR_W   (ADDR_W),
      .OFFSET_W (OFFSET_W)
   ) u_next (
      .pc            (pc),
      .offset        (BranchOffset),
      .pc_plus2      (pc_plus2),
      .branch_target (branch_target)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state and request logic
   always_comb begin
      next_state = state;
      fetch_req  = 1'b0;
      case (state)
         ST_IDLE:   next_state = ST_FETCH;
         ST_FETCH: begin
            // A request already outstanding is not withdrawn by Stall.
            fetch_req = !Stall || req_held;
            if (fetch_req && FetchAck) next_state = ST_DECODE;
         end
         ST_DECODE: begin
            if (DecValid) next_state = Halt ? ST_HALT : ST_FETCH;
         end
         ST_HALT: begin
            if (Resume) next_state = ST_FETCH;
         end
         default:   next_state = ST_IDLE;
      endcase
   end

   // PC register, request tracking, capture pulse and sticky alignment flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_VECTOR;
         req_held    <= 1'b0;
         instr_valid <= 1'b0;
         align_err   <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         if (state == ST_FETCH && fetch_req) begin
            if (FetchAck) begin
               req_held    <= 1'b0;
               instr_valid <= 1'b1;
            end else begin
               req_held    <= 1'b1;
            end
         end
         if (state == ST_DECODE && DecValid) begin
            if (Halt) begin
               pc <= pc_plus2;
            end else if (Jump) begin
               pc <= {JumpTarget[ADDR_W-1:1], 1'b0};
               if (JumpTarget[0]) align_err <= 1'b1;
            end else if (BranchTaken) begin
               pc <= branch_target;
            end else begin
               pc <= pc_plus2;
            end
         end
      end
   end

   assign FetchReq   = fetch_req;
   assign FetchAddr  = pc;
   assign PC         = pc;
   assign PCPlus2    = pc_plus2;
   assign InstrValid = instr_valid;
   assign AlignErr   = align_err;
   assign State      = state;

endmodule
